// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL lock sequencer: state encoding,
// default timing constants and the statistics counter width.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } pll_state_e;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_STABLE_CYCLES       = 1024;
  localparam int DEF_RELEASE_GAP_CYCLES  = 8;
  localparam int DEF_CNT_W               = 16;

  localparam int STATS_W = 8;

  // Saturating increment for the statistics counters.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock qualification sequencer releasing ctrl_rst then user_rst.
// Optional retry/loss statistics outputs are enabled by PLL_LOCK_STATS_EN.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int STABLE_CYCLES       = DEF_STABLE_CYCLES,
  parameter int RELEASE_GAP_CYCLES  = DEF_RELEASE_GAP_CYCLES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               ctrl_rst,
  output logic               user_rst,
  output logic               ready,
  output logic               timeout_err,
`ifdef PLL_LOCK_STATS_EN
  output logic [STATS_W-1:0] retry_cnt,
  output logic [STATS_W-1:0] lossl_cnt,
`endif
  output logic [2:0]         state_o
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(RELEASE_GAP_CYCLES - 1);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pll_rst_q, pll_rst_d;
  logic             ctrl_rst_q, ctrl_rst_d;
  logic             user_rst_q, user_rst_d;
  logic             ready_q, ready_d;
  logic             timeout_err_q, timeout_err_d;
  logic             locked_s;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

`ifdef PLL_LOCK_STATS_EN
  logic [STATS_W-1:0] retry_q, retry_d;
  logic [STATS_W-1:0] lossl_q, lossl_d;
  logic               loss_evt;
`endif

  // State register and all registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q       <= ST_PLL_RST;
      cnt_q         <= '0;
      pll_rst_q     <= 1'b1;
      ctrl_rst_q    <= 1'b1;
      user_rst_q    <= 1'b1;
      ready_q       <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef PLL_LOCK_STATS_EN
      retry_q       <= '0;
      lossl_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pll_rst_q     <= pll_rst_d;
      ctrl_rst_q    <= ctrl_rst_d;
      user_rst_q    <= user_rst_d;
      ready_q       <= ready_d;
      timeout_err_q <= timeout_err_d;
`ifdef PLL_LOCK_STATS_EN
      retry_q       <= retry_d;
      lossl_q       <= lossl_d;
`endif
    end
  end

  // Next state; relock_req outranks lock loss, which outranks counter expiry.
  always_comb begin
    state_d       = state_q;
    timeout_err_d = 1'b0;
`ifdef PLL_LOCK_STATS_EN
    loss_evt      = 1'b0;
`endif
    unique case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (relock_req) state_d = ST_PLL_RST;
        else if (locked_s) state_d = ST_STABLE;
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d       = ST_PLL_RST;
          timeout_err_d = 1'b1;
        end
      end
      ST_STABLE: begin
        if (relock_req) state_d = ST_PLL_RST;
        else if (!locked_s) state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (relock_req) state_d = ST_PLL_RST;
        else if (!locked_s) begin
          state_d = ST_PLL_RST;
`ifdef PLL_LOCK_STATS_EN
          loss_evt = 1'b1;
`endif
        end else if (cnt_q == GAP_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (relock_req) state_d = ST_PLL_RST;
        else if (!locked_s) begin
          state_d = ST_PLL_RST;
`ifdef PLL_LOCK_STATS_EN
          loss_evt = 1'b1;
`endif
        end
      end
      default: state_d = ST_PLL_RST;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  // Outputs decoded from the next state so they move with the state register.
  always_comb begin
    pll_rst_d  = (state_d == ST_PLL_RST);
    ctrl_rst_d = (state_d == ST_PLL_RST) || (state_d == ST_WAIT_LOCK) ||
                 (state_d == ST_STABLE);
    user_rst_d = (state_d != ST_RUN);
    ready_d    = (state_d == ST_RUN);
`ifdef PLL_LOCK_STATS_EN
    retry_d    = timeout_err_d ? sat_inc(retry_q) : retry_q;
    lossl_d    = loss_evt ? sat_inc(lossl_q) : lossl_q;
`endif
  end

  assign pll_rst     = pll_rst_q;
  assign ctrl_rst    = ctrl_rst_q;
  assign user_rst    = user_rst_q;
  assign ready       = ready_q;
  assign timeout_err = timeout_err_q;
  assign state_o     = state_q;
`ifdef PLL_LOCK_STATS_EN
  assign retry_cnt   = retry_q;
  assign lossl_cnt   = lossl_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with RST_PULSE=4, LOCK_TIMEOUT=20,
// STABLE=8, RELEASE_GAP=3. Stats outputs are checked when PLL_LOCK_STATS_EN is set.
module tb_pll_lock_sequencer;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       ctrl_rst;
  logic       user_rst;
  logic       ready;
  logic       timeout_err;
  logic [2:0] state_o;
`ifdef PLL_LOCK_STATS_EN
  logic [7:0] retry_cnt;
  logic [7:0] lossl_cnt;
`endif

  int checks;
  int failures;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .STABLE_CYCLES       (8),
    .RELEASE_GAP_CYCLES  (3),
    .CNT_W               (16)
  ) dut (
    .refclk      (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .relock_req  (relock_req),
    .pll_rst     (pll_rst),
    .ctrl_rst    (ctrl_rst),
    .user_rst    (user_rst),
    .ready       (ready),
    .timeout_err (timeout_err),
`ifdef PLL_LOCK_STATS_EN
    .retry_cnt   (retry_cnt),
    .lossl_cnt   (lossl_cnt),
`endif
    .state_o     (state_o)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock edge, then sample 1 ns later; reset ordering invariant checked every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if ((user_rst === 1'b0 && ctrl_rst !== 1'b0) || (ready !== (state_o === 3'd4))) begin
      failures++;
      $display("FAIL invariant: state=%0d ctrl_rst=%b user_rst=%b ready=%b (need user_rst=0 -> ctrl_rst=0, ready iff state 4)",
               state_o, ctrl_rst, user_rst, ready);
    end
  endtask

  // Expects the DUT to have just entered PLL_RST with pll_locked low; the PLL locks
  // right after WAIT_LOCK is entered and the sequence runs to RUN.
  task automatic run_lock_sequence(input string tag);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (state_o !== 3'd0 || pll_rst !== 1'b1) begin
        failures++;
        $display("FAIL %s_pll_rst_hold c%0d: state=%0d pll_rst=%b need state=0 pll_rst=1", tag, i, state_o, pll_rst);
      end
    end
    tick();
    checks++;
    if (state_o !== 3'd1 || pll_rst !== 1'b0 || ctrl_rst !== 1'b1 || user_rst !== 1'b1) begin
      failures++;
      $display("FAIL %s_wait_entry: state=%0d pll_rst=%b ctrl_rst=%b user_rst=%b need 1/0/1/1", tag, state_o, pll_rst, ctrl_rst, user_rst);
    end
    pll_locked = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if (state_o !== 3'd1) begin
        failures++;
        $display("FAIL %s_sync_latency c%0d: state=%0d need 1", tag, i, state_o);
      end
    end
    for (int i = 0; i <= 7; i++) begin
      tick();
      checks++;
      if (state_o !== 3'd2 || ctrl_rst !== 1'b1) begin
        failures++;
        $display("FAIL %s_stable c%0d: state=%0d ctrl_rst=%b need state=2 ctrl_rst=1", tag, i, state_o, ctrl_rst);
      end
    end
    tick();
    checks++;
    if (state_o !== 3'd3 || ctrl_rst !== 1'b0 || user_rst !== 1'b1 || ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_ctrl_release: state=%0d ctrl_rst=%b user_rst=%b ready=%b need 3/0/1/0", tag, state_o, ctrl_rst, user_rst, ready);
    end
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if (state_o !== 3'd3 || user_rst !== 1'b1) begin
        failures++;
        $display("FAIL %s_gap c%0d: state=%0d user_rst=%b need state=3 user_rst=1", tag, i, state_o, user_rst);
      end
    end
    tick();
    checks++;
    if (state_o !== 3'd4 || user_rst !== 1'b0 || ctrl_rst !== 1'b0 || pll_rst !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_run: state=%0d pll_rst=%b ctrl_rst=%b user_rst=%b ready=%b need 4/0/0/0/1", tag, state_o, pll_rst, ctrl_rst, user_rst, ready);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    tick();
    tick();
    checks++;
    if (state_o !== 3'd0 || pll_rst !== 1'b1 || ctrl_rst !== 1'b1 || user_rst !== 1'b1 ||
        ready !== 1'b0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: state=%0d pll=%b ctrl=%b user=%b ready=%b to=%b need 0/1/1/1/0/0",
               state_o, pll_rst, ctrl_rst, user_rst, ready, timeout_err);
    end
`ifdef PLL_LOCK_STATS_EN
    checks++;
    if (retry_cnt !== 8'd0 || lossl_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_stats: retry=%0d lossl=%0d need 0/0", retry_cnt, lossl_cnt);
    end
`endif
  endtask

  task automatic test_lock_sequence();
    rst = 1'b0;
    run_lock_sequence("seq");
  endtask

  task automatic test_lock_loss();
    pll_locked = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if (state_o !== 3'd4 || ready !== 1'b1 || pll_rst !== 1'b0) begin
        failures++;
        $display("FAIL loss_sync c%0d: state=%0d ready=%b pll_rst=%b need 4/1/0", i, state_o, ready, pll_rst);
      end
    end
    tick();
    checks++;
    if (state_o !== 3'd0 || pll_rst !== 1'b1 || ctrl_rst !== 1'b1 || user_rst !== 1'b1 || ready !== 1'b0) begin
      failures++;
      $display("FAIL loss_reset: state=%0d pll=%b ctrl=%b user=%b ready=%b need 0/1/1/1/0",
               state_o, pll_rst, ctrl_rst, user_rst, ready);
    end
`ifdef PLL_LOCK_STATS_EN
    checks++;
    if (lossl_cnt !== 8'd1) begin
      failures++;
      $display("FAIL loss_stat: lossl=%0d need 1", lossl_cnt);
    end
`endif
    run_lock_sequence("relock");
  endtask

  task automatic test_relock_req();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    checks++;
    if (state_o !== 3'd0 || pll_rst !== 1'b1 || ctrl_rst !== 1'b1 || user_rst !== 1'b1 ||
        ready !== 1'b0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL relock_run: state=%0d pll=%b ctrl=%b user=%b ready=%b to=%b need 0/1/1/1/0/0",
               state_o, pll_rst, ctrl_rst, user_rst, ready, timeout_err);
    end
    pll_locked = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    checks++;
    if (state_o !== 3'd1) begin
      failures++;
      $display("FAIL relock_wait_entry: state=%0d need 1", state_o);
    end
    for (int i = 1; i <= 19; i++) begin
      tick();
      checks++;
      if (state_o !== 3'd1 || timeout_err !== 1'b0) begin
        failures++;
        $display("FAIL relock_wait c%0d: state=%0d to=%b need 1/0", i, state_o, timeout_err);
      end
    end
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    checks++;
    if (state_o !== 3'd0 || pll_rst !== 1'b1 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL relock_vs_timeout: state=%0d pll_rst=%b to=%b need 0/1/0", state_o, pll_rst, timeout_err);
    end
    tick();
    checks++;
    if (timeout_err !== 1'b0 || state_o !== 3'd0) begin
      failures++;
      $display("FAIL relock_vs_timeout_after: state=%0d to=%b need 0/0", state_o, timeout_err);
    end
`ifdef PLL_LOCK_STATS_EN
    checks++;
    if (retry_cnt !== 8'd0) begin
      failures++;
      $display("FAIL relock_retry_stat: retry=%0d need 0", retry_cnt);
    end
`endif
  endtask

  task automatic test_timeout();
    int pulses;
    logic exp_to, exp_pll;
    pulses     = 0;
    pll_locked = 1'b0;
    rst        = 1'b1;
    tick();
    rst        = 1'b0;
    // Each attempt is 4 cycles of PLL_RST plus 20 cycles of WAIT_LOCK.
    for (int c = 1; c <= 72; c++) begin
      tick();
      exp_to  = ((c % 24) == 0);
      exp_pll = ((c % 24) < 4);
      if (timeout_err === 1'b1) pulses++;
      checks++;
      if (timeout_err !== exp_to || pll_rst !== exp_pll) begin
        failures++;
        $display("FAIL timeout c%0d: to=%b pll_rst=%b need to=%b pll_rst=%b", c, timeout_err, pll_rst, exp_to, exp_pll);
      end
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL timeout_count: pulses=%0d need 3", pulses);
    end
`ifdef PLL_LOCK_STATS_EN
    checks++;
    if (retry_cnt !== 8'd3) begin
      failures++;
      $display("FAIL timeout_retry_stat: retry=%0d need 3", retry_cnt);
    end
`endif
  endtask

  task automatic test_lock_glitch();
    logic [2:0] exp_state;
    logic       exp_ctrl;
    pll_locked = 1'b1;
    rst        = 1'b1;
    tick();
    rst        = 1'b0;
    // Lock drops for edges 9..11 while STABLE; the FSM sees it at edges 11..13.
    for (int c = 1; c <= 22; c++) begin
      pll_locked = !(c >= 9 && c <= 11);
      tick();
      if (c <= 3)       exp_state = 3'd0;
      else if (c == 4)  exp_state = 3'd1;
      else if (c <= 10) exp_state = 3'd2;
      else if (c <= 13) exp_state = 3'd1;
      else if (c <= 21) exp_state = 3'd2;
      else              exp_state = 3'd3;
      exp_ctrl = (c < 22);
      checks++;
      if (state_o !== exp_state || ctrl_rst !== exp_ctrl) begin
        failures++;
        $display("FAIL glitch c%0d: state=%0d ctrl_rst=%b need state=%0d ctrl_rst=%b", c, state_o, ctrl_rst, exp_state, exp_ctrl);
      end
    end
  endtask

  task automatic test_rst_in_release();
    tick();
    checks++;
    if (state_o !== 3'd3) begin
      failures++;
      $display("FAIL rst_rel_pre: state=%0d need 3", state_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (state_o !== 3'd0 || pll_rst !== 1'b1 || ctrl_rst !== 1'b1 || user_rst !== 1'b1 ||
        ready !== 1'b0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_rel: state=%0d pll=%b ctrl=%b user=%b ready=%b to=%b need 0/1/1/1/0/0",
               state_o, pll_rst, ctrl_rst, user_rst, ready, timeout_err);
    end
`ifdef PLL_LOCK_STATS_EN
    checks++;
    if (retry_cnt !== 8'd0 || lossl_cnt !== 8'd0) begin
      failures++;
      $display("FAIL rst_rel_stats: retry=%0d lossl=%0d need 0/0", retry_cnt, lossl_cnt);
    end
`endif
    // Counter restarted from 0: full 4-cycle pll_rst pulse follows.
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (state_o !== 3'd0 || pll_rst !== 1'b1) begin
        failures++;
        $display("FAIL rst_rel_pulse c%0d: state=%0d pll_rst=%b need 0/1", i, state_o, pll_rst);
      end
    end
    tick();
    checks++;
    if (state_o !== 3'd1 || pll_rst !== 1'b0) begin
      failures++;
      $display("FAIL rst_rel_wait: state=%0d pll_rst=%b need 1/0", state_o, pll_rst);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    test_reset();
    test_lock_sequence();
    test_lock_loss();
    test_relock_req();
    test_timeout();
    test_lock_glitch();
    test_rst_in_release();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
